// File: rtl/conv_frame_feeder.sv
// conv_frame_feeder: buffers one N x N activation frame from a valid/ready write
// port, then replays it in raster order to the convolver as activation/conv_ce,
// pads with zero activations until end_conv, and pulses conv_rst before each frame.
// Optional feature macro: CONV_FEED_WATCHDOG_EN (flush watchdog with sticky wd_err).
module conv_frame_feeder #(
  parameter int unsigned N      = 10,
  parameter int unsigned BL     = 16,
  parameter int unsigned WD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BL-1:0] in_data,
  input  logic          hold,
  input  logic          end_conv,
  output logic          conv_rst,
  output logic          conv_ce,
  output logic [BL-1:0] activation,
  output logic          busy,
  output logic          done,
  output logic          wd_err
);

  localparam int unsigned DEPTH = N * N;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_addr_q;
  logic [AW-1:0]   rd_addr_q;
  logic            in_ready_q;
  logic            conv_rst_q;
  logic            conv_ce_q;
  logic [BL-1:0]   act_q;
  logic            busy_q;
  logic            done_q;
  logic [BL-1:0]   mem_q [DEPTH];

  logic            wr_fire;
  logic            wd_trip;
  logic            pad_issue;

  // Reject degenerate parameterisations at elaboration.
  if (N < 1 || BL < 1 || WD_MAX < 1) begin : g_param_check
    $error("conv_frame_feeder: N, BL and WD_MAX must all be at least 1");
  end

  assign wr_fire   = (state_q == S_LOAD) && in_valid && in_ready_q;
  // A pad ce is issued only when the flush is not ending this cycle and not stalled.
  assign pad_issue = (state_q == S_FLUSH) && !end_conv && !wd_trip && !hold;

  // Frame buffer write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_addr_q] <= in_data;
    end
  end

  // Main sequencer: load, convolver reset, stream, pad flush, completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      in_ready_q <= 1'b0;
      conv_rst_q <= 1'b0;
      conv_ce_q  <= 1'b0;
      act_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      conv_rst_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          conv_ce_q <= 1'b0;
          if (start) begin
            state_q    <= S_LOAD;
            wr_addr_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (wr_fire) begin
            wr_addr_q <= wr_addr_q + AW'(1);
            if (wr_addr_q == LAST_ADDR) begin
              state_q    <= S_CRST;
              in_ready_q <= 1'b0;
              conv_rst_q <= 1'b1;
            end
          end
        end
        S_CRST: begin
          rd_addr_q <= '0;
          state_q   <= S_STREAM;
        end
        S_STREAM: begin
          // Read and output register are merged: ce and data appear together.
          if (!hold) begin
            conv_ce_q <= 1'b1;
            act_q     <= mem_q[rd_addr_q];
            rd_addr_q <= rd_addr_q + AW'(1);
            if (rd_addr_q == LAST_ADDR) begin
              state_q <= S_FLUSH;
            end
          end else begin
            conv_ce_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          // end_conv (or a watchdog trip) outranks hold.
          if (end_conv || wd_trip) begin
            conv_ce_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (pad_issue) begin
            conv_ce_q <= 1'b1;
            act_q     <= '0;
          end else begin
            conv_ce_q <= 1'b0;
          end
        end
        S_DONE: begin
          conv_ce_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          conv_ce_q  <= 1'b0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_FEED_WATCHDOG_EN
  localparam int unsigned CW = $clog2(WD_MAX + 1);

  logic [CW-1:0] wd_cnt_q;
  logic          wd_err_q;

  assign wd_trip = (state_q == S_FLUSH) && !end_conv && (wd_cnt_q == CW'(WD_MAX));
  assign wd_err  = wd_err_q;

  // Flush watchdog: counts pad ce cycles; the count is zero whenever FLUSH is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (state_q != S_FLUSH) begin
        wd_cnt_q <= '0;
      end else if (pad_issue) begin
        wd_cnt_q <= wd_cnt_q + CW'(1);
      end
      if (wd_trip) begin
        wd_err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_trip = 1'b0;
  assign wd_err  = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign conv_rst   = conv_rst_q;
  assign conv_ce    = conv_ce_q;
  assign activation = act_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_frame_feeder.sv
// Directed bench for conv_frame_feeder (N=3): load, stream, hold, flush/end_conv,
// mid-frame reset and, when CONV_FEED_WATCHDOG_EN is defined, the flush watchdog.
module tb_conv_frame_feeder;

  localparam int unsigned N      = 3;
  localparam int unsigned BL     = 16;
  localparam int unsigned WD_MAX = 8;
  localparam int          DEPTH  = N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] in_data;
  logic          hold;
  logic          end_conv;
  logic          conv_rst;
  logic          conv_ce;
  logic [BL-1:0] activation;
  logic          busy;
  logic          done;
  logic          wd_err;

  conv_frame_feeder #(.N(N), .BL(BL), .WD_MAX(WD_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .hold       (hold),
    .end_conv   (end_conv),
    .conv_rst   (conv_rst),
    .conv_ce    (conv_ce),
    .activation (activation),
    .busy       (busy),
    .done       (done),
    .wd_err     (wd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-frame observations.
  int acts[$];
  int data_cnt, pad_cnt, pad_bad, rst_pulses, done_pulses, ce_after_end;
  int ready_late, hold_bad, sum, gap45, gap_max;
  int busy_at_done, wd_at_done, busy_after, done_after;
  bit aborted, timed_out;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame: start, load base+1..base+DEPTH, stream, flush until the end_conv policy ends it.
  //  end_pads   : raise end_conv once this many pad ce are seen (-1 = never)
  //  flush_hold : hold high for the whole flush
  //  stream_pulse: one-cycle end_conv right after this data ce (0 = none)
  //  abort_after: stop driving after this many data ce (0 = run to done)
  task automatic run_frame(input int base, input bit toggle, input int hold_after, input int hold_len,
                           input int end_pads, input bit flush_hold, input int stream_pulse,
                           input int abort_after);
    int w, cyc, hold_left, last_cyc;
    bit accept, end_prev, finished;
    w = 0; cyc = 0; hold_left = 0; last_cyc = 0; finished = 0; aborted = 0;
    acts.delete();
    data_cnt = 0; pad_cnt = 0; pad_bad = 0; rst_pulses = 0; done_pulses = 0; ce_after_end = 0;
    ready_late = 0; hold_bad = 0; sum = 0; gap45 = 0; gap_max = 0;
    busy_at_done = 0; wd_at_done = 0; busy_after = -1; done_after = -1;
    hold = 1'b0; end_conv = 1'b0; in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!finished && !aborted && cyc < 300) begin
      in_valid = (w < DEPTH) && (!toggle || (cyc % 2 == 0));
      in_data  = BL'(base + w + 1);
      accept   = in_valid && in_ready;
      end_prev = end_conv;
      tick();
      cyc++;
      if (accept) w++;
      if (w == DEPTH && in_ready) ready_late++;
      if (conv_rst) rst_pulses++;
      if (conv_ce) begin
        if (data_cnt < DEPTH) begin
          acts.push_back(int'(activation));
          sum += int'(activation);
          if (data_cnt == 4) gap45 = cyc - last_cyc;
          else if (data_cnt > 0 && cyc - last_cyc > gap_max) gap_max = cyc - last_cyc;
          last_cyc = cyc;
          data_cnt++;
          if (data_cnt == hold_after) hold_left = hold_len;
        end else begin
          pad_cnt++;
          if (activation != '0) pad_bad++;
          if (end_prev) ce_after_end++;
        end
      end else if (data_cnt > 0 && data_cnt < DEPTH && int'(activation) != acts[$]) begin
        hold_bad++;
      end
      if (done) begin
        done_pulses++;
        busy_at_done = int'(busy);
        wd_at_done   = int'(wd_err);
        finished     = 1'b1;
      end
      if (abort_after > 0 && data_cnt == abort_after) aborted = 1'b1;
      hold = (hold_left > 0) || (flush_hold && data_cnt == DEPTH);
      if (hold_left > 0) hold_left--;
      end_conv = (stream_pulse > 0 && conv_ce && data_cnt == stream_pulse) ||
                 (end_pads >= 0 && data_cnt == DEPTH && pad_cnt >= end_pads);
    end
    timed_out = !finished && !aborted;
    in_valid = 1'b0; hold = 1'b0; end_conv = 1'b0;
    if (finished) begin
      tick();
      busy_after = int'(busy);
      done_after = int'(done);
    end
  endtask

  // Common completion checks for a frame that ran to done.
  task automatic check_frame(input string tag, input int base);
    check_eq({tag, "_timeout"}, int'(timed_out), 0);
    check_eq({tag, "_conv_rst_pulses"}, rst_pulses, 1);
    check_eq({tag, "_done_pulses"}, done_pulses, 1);
    check_eq({tag, "_data_ce"}, data_cnt, DEPTH);
    for (int i = 0; i < acts.size(); i++) check_eq({tag, "_act"}, acts[i], base + i + 1);
    check_eq({tag, "_pad_nonzero"}, pad_bad, 0);
    check_eq({tag, "_ce_after_end_le1"}, int'(ce_after_end <= 1), 1);
    check_eq({tag, "_ready_after_last"}, ready_late, 0);
    check_eq({tag, "_busy_at_done"}, busy_at_done, 1);
    check_eq({tag, "_busy_after"}, busy_after, 0);
    check_eq({tag, "_done_width"}, done_after, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, int'(in_ready), 0);
    check_eq({tag, "_conv_rst"}, int'(conv_rst), 0);
    check_eq({tag, "_conv_ce"}, int'(conv_ce), 0);
    check_eq({tag, "_activation"}, int'(activation), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_wd_err"}, int'(wd_err), 0);
  endtask

  initial begin
    int late_done;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0; end_conv = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Back-to-back load, two pads before end_conv.
    run_frame(0, 1'b0, 0, 0, 2, 1'b0, 0, 0);
    check_frame("t1", 0);
    check_eq("t1_gap_max", gap_max, 1);
    check_eq("t1_gap45", gap45, 1);
    check_eq("t1_pads_ge2", int'(pad_cnt >= 2), 1);
    check_eq("t1_wd_err", wd_at_done, 0);

    // in_valid every other cycle.
    run_frame(30, 1'b1, 0, 0, 2, 1'b0, 0, 0);
    check_frame("t2", 30);
    check_eq("t2_gap_max", gap_max, 1);

    // Three hold cycles after the 4th data ce.
    run_frame(0, 1'b0, 4, 3, 1, 1'b0, 0, 0);
    check_frame("t3", 0);
    check_eq("t3_gap45", gap45, 4);
    check_eq("t3_hold_act", hold_bad, 0);
    check_eq("t3_gap_max", gap_max, 1);

    // Convolver stand-in: 3x3 ones kernel sums the nine activations 21..29.
    run_frame(20, 1'b0, 0, 0, 3, 1'b0, 0, 0);
    check_frame("t4", 20);
    check_eq("t4_sum", sum, 225);

    // end_conv pulse during STREAM is ignored.
    run_frame(40, 1'b0, 0, 0, 1, 1'b0, 2, 0);
    check_frame("t5", 40);

    // hold and end_conv together in FLUSH: end_conv wins, no pad issued.
    run_frame(50, 1'b0, 0, 0, 0, 1'b1, 0, 0);
    check_frame("t6", 50);
    check_eq("t6_pads", pad_cnt, 0);

    // Reset after the 5th data ce aborts with no done.
    run_frame(60, 1'b0, 0, 0, 2, 1'b0, 0, 5);
    check_eq("t7_aborted", int'(aborted), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t7_abort");
    rst = 1'b0;
    late_done = done_pulses;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) late_done++;
    end
    check_eq("t7_no_done", late_done, 0);
    run_frame(10, 1'b0, 0, 0, 2, 1'b0, 0, 0);
    check_frame("t7_restart", 10);

`ifdef CONV_FEED_WATCHDOG_EN
    // end_conv never arrives: WD_MAX pads then wd_err with done.
    run_frame(70, 1'b0, 0, 0, -1, 1'b0, 0, 0);
    check_frame("t8", 70);
    check_eq("t8_pads", pad_cnt, 8);
    check_eq("t8_wd_err_at_done", wd_at_done, 1);
    run_frame(0, 1'b0, 0, 0, 2, 1'b0, 0, 0);
    check_frame("t8_next", 0);
    check_eq("t8_wd_sticky", int'(wd_err), 1);
    rst = 1'b1;
    tick();
    check_eq("t8_wd_cleared", int'(wd_err), 0);
    rst = 1'b0;
`else
    check_eq("wd_err_tied", int'(wd_err), 0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
